// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction memory, and
// presents {pc, inst, inst_valid} to IFID. Optional HALT detection under `FETCH_HALT_EN`.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INST    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_to_new,
    input  logic [15:0] branch_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_q,
    output logic [15:0] pc,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic        halted
);

    logic [15:0] fetch_pc;
    logic [15:0] req_pc;
    logic        req_valid;
    logic [15:0] hold_inst;
    logic        hold_valid;
    logic [15:0] raw_inst;

    assign imem_addr  = fetch_pc;
    assign pc         = req_pc;
    // A stalled instruction is captured so later memory reads cannot overwrite it.
    assign raw_inst   = hold_valid ? hold_inst : imem_q;
    assign inst_valid = req_valid & ~branch_to_new;
    assign inst       = inst_valid ? raw_inst : NOP_INST;

`ifdef FETCH_HALT_EN
    logic halt_q;
    logic halt_hit;

    assign halt_hit = inst_valid & (inst[15:12] == HALT_OPCODE) & ~stall;
    assign halted   = halt_q;
`else
    logic unused_halt_opcode;

    assign unused_halt_opcode = ^HALT_OPCODE;
    assign halted             = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            req_pc     <= 16'h0000;
            req_valid  <= 1'b0;
            hold_inst  <= 16'h0000;
            hold_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            halt_q     <= 1'b0;
`endif
        end else if (branch_to_new) begin
            fetch_pc   <= branch_pc;
            req_valid  <= 1'b0;
            hold_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            halt_q     <= 1'b0;
`endif
`ifdef FETCH_HALT_EN
        end else if (halt_q || halt_hit) begin
            // Frozen until a branch (possibly cancelling a wrong-path HALT) or reset.
            halt_q     <= 1'b1;
            req_valid  <= 1'b0;
            hold_valid <= 1'b0;
`endif
        end else if (stall) begin
            if (!hold_valid) begin
                hold_inst  <= imem_q;
                hold_valid <= 1'b1;
            end
        end else begin
            req_pc     <= fetch_pc;
            req_valid  <= 1'b1;
            fetch_pc   <= fetch_pc + 16'd1;
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; a second instance covers the PC wrap case.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_to_new = 1'b0;
    logic [15:0] branch_pc = 16'h0000;

    logic [15:0] imem_addr, imem_q, pc, inst;
    logic        inst_valid, halted;
    logic [15:0] w_imem_addr, w_imem_q, w_pc, w_inst;
    logic        w_inst_valid, w_halted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory image: 16'h1000 + addr, with a HALT word placed at 0x0080.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0080) return 16'hF000;
        return 16'h1000 + a;
    endfunction

    always_ff @(posedge clk) imem_q <= mem_word(imem_addr);
    always_ff @(posedge clk) w_imem_q <= mem_word(w_imem_addr);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_to_new(branch_to_new),
        .branch_pc(branch_pc), .imem_addr(imem_addr), .imem_q(imem_q), .pc(pc),
        .inst(inst), .inst_valid(inst_valid), .halted(halted)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst), .stall(stall), .branch_to_new(branch_to_new),
        .branch_pc(branch_pc), .imem_addr(w_imem_addr), .imem_q(w_imem_q), .pc(w_pc),
        .inst(w_inst), .inst_valid(w_inst_valid), .halted(w_halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        branch_to_new = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp_pc;
        do_reset();
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid);
        end
        n_cmp++;
        if (pc !== 16'h0000 || inst !== 16'h0000) begin
            n_err++; $display("FAIL reset_pc_inst: got %h/%h want 0000/0000", pc, inst);
        end
        n_cmp++;
        if (imem_addr !== 16'h0000 || halted !== 1'b0) begin
            n_err++; $display("FAIL reset_addr_halt: got %h/%b want 0000/0", imem_addr, halted);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc = 16'(i);
            n_cmp++;
            if (inst_valid !== 1'b1 || pc !== exp_pc || inst !== 16'h1000 + exp_pc) begin
                n_err++;
                $display("FAIL stream_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, inst_valid, pc, inst, exp_pc, 16'h1000 + exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        tick();
        n_cmp++;
        if (pc !== 16'h0002 || inst !== 16'h1002 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_pre: got %h/%h/%b want 0002/1002/1", pc, inst, inst_valid);
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (pc !== 16'h0002 || inst !== 16'h1002 || inst_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold_%0d: got %h/%h/%b want 0002/1002/1",
                         k, pc, inst, inst_valid);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (pc !== 16'h0003 || inst !== 16'h1003 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_rel1: got %h/%h/%b want 0003/1003/1", pc, inst, inst_valid);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0004 || inst !== 16'h1004 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_rel2: got %h/%h/%b want 0004/1004/1", pc, inst, inst_valid);
        end
    endtask

    task automatic test_branch(input logic with_stall);
        branch_to_new = 1'b1;
        branch_pc = 16'h0040;
        stall = with_stall;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 16'h0000) begin
            n_err++; $display("FAIL br%0d_t: got %b/%h want 0/0000", with_stall, inst_valid, inst);
        end
        tick();
        branch_to_new = 1'b0;
        stall = 1'b0;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_addr !== 16'h0040) begin
            n_err++;
            $display("FAIL br%0d_t1: got v=%b addr=%h want 0/0040", with_stall, inst_valid, imem_addr);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0040 || inst !== 16'h1040 || inst_valid !== 1'b1) begin
            n_err++;
            $display("FAIL br%0d_t2: got %h/%h/%b want 0040/1040/1", with_stall, pc, inst, inst_valid);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0041 || inst !== 16'h1041) begin
            n_err++; $display("FAIL br%0d_t3: got %h/%h want 0041/1041", with_stall, pc, inst);
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || pc !== 16'h0000) begin
            n_err++; $display("FAIL rst_stall_t0: got %b/%h want 0/0000", inst_valid, pc);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0000 || inst !== 16'h1000 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_stall_t1: got %h/%h/%b want 0000/1000/1", pc, inst, inst_valid);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [4];
        logic [15:0] exp_in [4];
        exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_in = '{16'h0FFE, 16'h0FFF, 16'h1000, 16'h1001};
        do_reset();
        n_cmp++;
        if (w_inst_valid !== 1'b0 || w_imem_addr !== 16'hFFFE) begin
            n_err++; $display("FAIL wrap_reset: got %b/%h want 0/fffe", w_inst_valid, w_imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (w_inst_valid !== 1'b1 || w_pc !== exp_pc[i] || w_inst !== exp_in[i]) begin
                n_err++;
                $display("FAIL wrap_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, w_inst_valid, w_pc, w_inst, exp_pc[i], exp_in[i]);
            end
        end
    endtask

    task automatic test_halt();
        branch_to_new = 1'b1;
        branch_pc = 16'h0080;
        tick();
        branch_to_new = 1'b0;
        tick();
        n_cmp++;
        if (pc !== 16'h0080 || inst !== 16'hF000 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL halt_inst: got %h/%h/%b want 0080/f000/1", pc, inst, inst_valid);
        end
        tick();
`ifdef FETCH_HALT_EN
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (inst_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 16'h0081) begin
                n_err++;
                $display("FAIL halt_hold_%0d: got v=%b h=%b addr=%h want 0/1/0081",
                         k, inst_valid, halted, imem_addr);
            end
            tick();
        end
        branch_to_new = 1'b1;
        branch_pc = 16'h0010;
        tick();
        branch_to_new = 1'b0;
        #1;
        n_cmp++;
        if (halted !== 1'b0 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL halt_clear: got h=%b v=%b want 0/0", halted, inst_valid);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0010 || inst !== 16'h1010 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL halt_redir: got %h/%h/%b want 0010/1010/1", pc, inst, inst_valid);
        end
`else
        n_cmp++;
        if (pc !== 16'h0081 || inst !== 16'h1081 || inst_valid !== 1'b1 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt_passthru: got %h/%h/%b/%b want 0081/1081/1/0",
                     pc, inst, inst_valid, halted);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch(1'b0);
        test_branch(1'b1);
        test_reset_mid_stall();
        test_wrap();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
